// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared size encodings, tracking-entry layout and misalignment rule
package lsu_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int LANES = XLEN / 8;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       usign;
    logic       read;
    logic       misalgn;
  } lsu_entry_t;
  localparam int ENTRY_W = $bits(lsu_entry_t);
  function automatic logic is_misalgn(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_H && off[0]) || (size[1] && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: AGU command, memory cmd/rsp and write-back channels of the LSU
interface lsu_ctrl_if #(parameter int ADDR_SIZE = 32);
  import lsu_ctrl_pkg::*;
  logic                 agu_icb_cmd_valid;
  logic                 agu_icb_cmd_ready;
  logic [ADDR_SIZE-1:0] agu_icb_cmd_addr;
  logic                 agu_icb_cmd_read;
  logic [XLEN-1:0]      agu_icb_cmd_wdata;
  logic [1:0]           agu_icb_cmd_size;
  logic                 agu_icb_cmd_usign;
  logic                 mem_cmd_valid;
  logic                 mem_cmd_ready;
  logic [ADDR_SIZE-1:0] mem_cmd_addr;
  logic                 mem_cmd_read;
  logic [XLEN-1:0]      mem_cmd_wdata;
  logic [LANES-1:0]     mem_cmd_wmask;
  logic                 mem_rsp_valid;
  logic                 mem_rsp_ready;
  logic [XLEN-1:0]      mem_rsp_rdata;
  logic                 mem_rsp_err;
  logic                 lsu_o_valid;
  logic                 lsu_o_ready;
  logic [XLEN-1:0]      lsu_o_wbck_wdat;
  logic                 lsu_o_cmt_ld;
  logic                 lsu_o_cmt_st;
  logic                 lsu_o_err;
  modport slave (
    input  agu_icb_cmd_valid, agu_icb_cmd_addr, agu_icb_cmd_read, agu_icb_cmd_wdata,
           agu_icb_cmd_size, agu_icb_cmd_usign, mem_cmd_ready, mem_rsp_valid,
           mem_rsp_rdata, mem_rsp_err, lsu_o_ready,
    output agu_icb_cmd_ready, mem_cmd_valid, mem_cmd_addr, mem_cmd_read, mem_cmd_wdata,
           mem_cmd_wmask, mem_rsp_ready, lsu_o_valid, lsu_o_wbck_wdat, lsu_o_cmt_ld,
           lsu_o_cmt_st, lsu_o_err
  );
  modport master (
    output agu_icb_cmd_valid, agu_icb_cmd_addr, agu_icb_cmd_read, agu_icb_cmd_wdata,
           agu_icb_cmd_size, agu_icb_cmd_usign, mem_cmd_ready, mem_rsp_valid,
           mem_rsp_rdata, mem_rsp_err, lsu_o_ready,
    input  agu_icb_cmd_ready, mem_cmd_valid, mem_cmd_addr, mem_cmd_read, mem_cmd_wdata,
           mem_cmd_wmask, mem_rsp_ready, lsu_o_valid, lsu_o_wbck_wdat, lsu_o_cmt_ld,
           lsu_o_cmt_st, lsu_o_err
  );
endinterface

// File: rtl/lsu_outs_fifo.sv
// lsu_outs_fifo: in-order tracking FIFO for outstanding LSU requests
module lsu_outs_fifo #(
  parameter int W = 7,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(D - 1) ? '0 : p + 1'b1;
  endfunction
  assign full_o   = cnt_q == CW'(D);
  assign empty_o  = cnt_q == '0;
  assign do_push  = push_i & !full_o;
  assign do_pop   = pop_i & !empty_o;
  assign dout_o   = mem_q[rd_ptr_q];
  assign wr_ptr_d = do_push ? nxt(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d = do_pop ? nxt(rd_ptr_q) : rd_ptr_q;
  assign cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  // pointer and occupancy state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  // entry storage; unreset because the head is only used while non-empty
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= din_i;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: pipelined load/store unit between the AGU and the data-memory bus
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int OUTS_DEPTH = 2
) (
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave bus
);
  logic [1:0]      off, sz;
  logic            mis, full, empty, push, pop, sgn;
  lsu_entry_t      ent, head;
  logic [XLEN-1:0] d, ld_data;
  assign off  = bus.agu_icb_cmd_addr[1:0];
  assign sz   = bus.agu_icb_cmd_size;
  assign mis  = is_misalgn(sz, off);
  assign bus.agu_icb_cmd_ready = !full & (mis | bus.mem_cmd_ready);
  assign bus.mem_cmd_valid     = bus.agu_icb_cmd_valid & !mis & !full;
  assign bus.mem_cmd_addr      = {bus.agu_icb_cmd_addr[ADDR_SIZE-1:2], 2'b00};
  assign bus.mem_cmd_read      = bus.agu_icb_cmd_read;
  assign bus.mem_cmd_wmask     = bus.agu_icb_cmd_read ? '0 :
                                 sz == SZ_B ? 4'b0001 << off :
                                 sz == SZ_H ? 4'b0011 << off : 4'b1111;
  assign bus.mem_cmd_wdata     = sz == SZ_B ? {4{bus.agu_icb_cmd_wdata[7:0]}} :
                                 sz == SZ_H ? {2{bus.agu_icb_cmd_wdata[15:0]}} :
                                 bus.agu_icb_cmd_wdata;
  assign push = bus.agu_icb_cmd_valid & bus.agu_icb_cmd_ready;
  assign ent  = '{off: off, size: sz, usign: bus.agu_icb_cmd_usign,
                  read: bus.agu_icb_cmd_read, misalgn: mis};
  lsu_outs_fifo #(.W(ENTRY_W), .D(OUTS_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (ent),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty)
  );
  assign d       = bus.mem_rsp_rdata >> {head.off, 3'b000};
  assign sgn     = !head.usign & (head.size == SZ_B ? d[7] : d[15]);
  assign ld_data = head.size == SZ_B ? {{24{sgn}}, d[7:0]} :
                   head.size == SZ_H ? {{16{sgn}}, d[15:0]} : d;
  assign bus.lsu_o_valid     = !empty & (head.misalgn | bus.mem_rsp_valid);
  assign bus.mem_rsp_ready   = !empty & !head.misalgn & bus.lsu_o_ready;
  assign pop                 = bus.lsu_o_valid & bus.lsu_o_ready;
  assign bus.lsu_o_err       = !empty & (head.misalgn | bus.mem_rsp_err);
  assign bus.lsu_o_cmt_ld    = !empty & head.read;
  assign bus.lsu_o_cmt_st    = !empty & !head.read;
  assign bus.lsu_o_wbck_wdat = (!empty & head.read & !bus.lsu_o_err) ? ld_data : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl against a queue-based model
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  lsu_ctrl_if #(.ADDR_SIZE(32)) bus ();
  lsu_ctrl #(.ADDR_SIZE(32), .OUTS_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [1:0] off;
    logic [1:0] size;
    logic       usign;
    logic       read;
    logic       mis;
  } op_t;
  op_t rq[$];
  int mcnt, n_chk, n_pass, rsp_mode;
  logic a_valid, a_read, a_usign, m_rdy, wb_rdy, force_rsp, rerr;
  logic [31:0] a_addr, a_wdata, r_data;
  logic [1:0] a_size;
  logic o_ready, o_mvalid, o_valid, o_err, o_st, o_ld;
  logic [3:0] o_wmask;
  logic [31:0] o_mwdata, o_wdat;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask
  task automatic set_op(input logic v, input logic [31:0] addr, input logic rd,
                        input logic [1:0] size, input logic us, input logic [31:0] wd);
    a_valid = v; a_addr = addr; a_read = rd; a_size = size; a_usign = us; a_wdata = wd;
  endtask
  function automatic logic [31:0] exp_load(input op_t h, input logic [31:0] rd);
    int unsigned v = rd >> (8 * h.off);
    if (h.size == 0) begin
      v = v % 256;
      if (!h.usign && v >= 128) v = v + 32'hFFFFFF00;
    end else if (h.size == 1) begin
      v = v % 65536;
      if (!h.usign && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction
  task automatic cycle();
    logic rv, mis, full, exp_ov, e_err, cmd_ok;
    logic [31:0] rd, e_mask, e_wd;
    int off;
    op_t h;
    rv = force_rsp | (mcnt > 0 && (rsp_mode == 1 || (rsp_mode == 2 && $urandom_range(1, 0) == 1)));
    rd = rsp_mode == 2 ? $urandom : r_data;
    bus.agu_icb_cmd_valid = a_valid;
    bus.agu_icb_cmd_addr  = a_addr;
    bus.agu_icb_cmd_read  = a_read;
    bus.agu_icb_cmd_wdata = a_wdata;
    bus.agu_icb_cmd_size  = a_size;
    bus.agu_icb_cmd_usign = a_usign;
    bus.mem_cmd_ready     = m_rdy;
    bus.mem_rsp_valid     = rv;
    bus.mem_rsp_rdata     = rd;
    bus.mem_rsp_err       = rv & (rsp_mode == 2 ? $urandom_range(7, 0) == 0 : rerr);
    bus.lsu_o_ready       = wb_rdy;
    @(negedge clk);
    o_ready = bus.agu_icb_cmd_ready; o_mvalid = bus.mem_cmd_valid; o_valid = bus.lsu_o_valid;
    o_err = bus.lsu_o_err; o_st = bus.lsu_o_cmt_st; o_ld = bus.lsu_o_cmt_ld;
    o_wmask = bus.mem_cmd_wmask; o_mwdata = bus.mem_cmd_wdata; o_wdat = bus.lsu_o_wbck_wdat;
    off = int'(a_addr % 4);
    mis = (a_size == 1 && off % 2 != 0) || (a_size >= 2 && off != 0);
    full = rq.size() >= DEPTH;
    cmd_ok = a_valid && !mis && !full;
    check("agu_ready", o_ready, !full && (mis || m_rdy));
    check("mem_valid", o_mvalid, cmd_ok);
    if (cmd_ok) begin
      e_mask = a_read ? 0 : a_size == 0 ? 1 << off : a_size == 1 ? 3 << off : 15;
      e_wd = a_size == 0 ? (a_wdata % 256) * 32'h01010101 :
             a_size == 1 ? (a_wdata % 65536) * 32'h00010001 : a_wdata;
      check("mem_addr", bus.mem_cmd_addr, a_addr - off);
      check("mem_read", bus.mem_cmd_read, a_read);
      check("mem_wmask", o_wmask, e_mask);
      check("mem_wdata", o_mwdata, e_wd);
    end
    exp_ov = rq.size() > 0 && (rq[0].mis || rv);
    check("rsp_ready", bus.mem_rsp_ready, rq.size() > 0 && !rq[0].mis && wb_rdy);
    check("o_valid", o_valid, exp_ov);
    if (exp_ov) begin
      h = rq[0];
      e_err = h.mis || bus.mem_rsp_err;
      check("o_err", o_err, e_err);
      check("o_cmt_ld", o_ld, h.read);
      check("o_cmt_st", o_st, !h.read);
      check("o_wdat", o_wdat, (h.read && !e_err) ? exp_load(h, rd) : 0);
    end
    if (rv && rq.size() > 0 && !rq[0].mis && wb_rdy) mcnt--;
    if (exp_ov && wb_rdy) void'(rq.pop_front());
    if (a_valid && !full && (mis || m_rdy))
      rq.push_back('{off: a_addr[1:0], size: a_size, usign: a_usign, read: a_read, mis: mis});
    if (cmd_ok && m_rdy) mcnt++;
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    a_valid = 0; rsp_mode = 1; m_rdy = 1; wb_rdy = 1;
    for (int i = 0; i < 4; i++) cycle();
  endtask
  initial begin
    n_chk = 0; n_pass = 0; mcnt = 0; rsp_mode = 0; r_data = 0; rerr = 0;
    m_rdy = 1; wb_rdy = 1; force_rsp = 1;
    set_op(0, 0, 1, 2, 0, 0);
    cycle();
    check("rst_valid", o_valid, 0);
    check("rst_wdat", o_wdat, 0);
    check("rst_cmt", {o_ld, o_st, o_err}, 0);
    force_rsp = 0; rst_n = 1;
    cycle();
    rsp_mode = 1; r_data = 32'hDEADBEEF;
    set_op(1, 32'h80000004, 1, 2, 0, 0); cycle();
    a_valid = 0; cycle();
    check("t1_valid", o_valid, 1);
    check("t1_wdat", o_wdat, 32'hDEADBEEF);
    check("t1_ld", o_ld, 1);
    r_data = 32'h80FF0000;
    set_op(1, 32'h80000003, 1, 0, 0, 0); cycle();
    a_valid = 0; cycle();
    check("t2_lb", o_wdat, 32'hFFFFFF80);
    set_op(1, 32'h80000003, 1, 0, 1, 0); cycle();
    a_valid = 0; cycle();
    check("t2_lbu", o_wdat, 32'h00000080);
    set_op(1, 32'h80000002, 0, 1, 0, 32'h1234); cycle();
    check("t3_wmask", o_wmask, 4'b1100);
    check("t3_wdata", o_mwdata, 32'h12341234);
    a_valid = 0; cycle();
    check("t3_st", o_st, 1);
    drain();
    rsp_mode = 0;
    set_op(1, 32'h80000000, 1, 2, 0, 0); cycle();
    set_op(1, 32'h80000001, 1, 2, 0, 0); cycle();
    check("t4_nocmd", o_mvalid, 0);
    a_valid = 0; rsp_mode = 1; r_data = 32'h11111111; cycle();
    check("t4_first", o_wdat, 32'h11111111);
    cycle();
    check("t4_err", o_err, 1);
    check("t4_wdat", o_wdat, 0);
    drain();
    rsp_mode = 0;
    set_op(1, 32'h10, 1, 2, 0, 0); cycle();
    set_op(1, 32'h14, 1, 2, 0, 0); cycle();
    set_op(1, 32'h18, 1, 2, 0, 0); cycle();
    check("t5_stall", o_ready, 0);
    rsp_mode = 1; cycle();
    check("t5_popfull", o_ready, 0);
    cycle();
    check("t5_accept", o_ready, 1);
    drain();
    rsp_mode = 0;
    set_op(1, 32'h20, 1, 2, 0, 0); cycle();
    set_op(1, 32'h24, 1, 2, 0, 0); cycle();
    a_valid = 0;
    rst_n = 0; rq.delete(); mcnt = 0; force_rsp = 1;
    cycle();
    check("t6_valid", o_valid, 0);
    rst_n = 1; force_rsp = 0;
    cycle();
    rsp_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      set_op($urandom_range(9, 0) < 7, $urandom, $urandom_range(1, 0), 2'($urandom_range(3, 0)),
             $urandom_range(1, 0), $urandom);
      m_rdy = $urandom_range(3, 0) != 0;
      wb_rdy = $urandom_range(3, 0) != 0;
      cycle();
    end
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
